te_radio_seq: RTL and testbench

Receiving-end sequencer for the timing-engine signal set: consumes `pllSettled` and `tArstFs` as produced by the more-on source domain and generates `radioEnable` / `radioRxEn` in a controlled power-up order. It sits in a switchable domain downstream of the source. It tolerates the source being isolated at any time and reports PLL lock timeouts back to software.

---
 rtl/te_radio_seq.sv | 138 +++++++++++++
 tb/tb_te_radio_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/te_radio_seq.sv
// Radio power-up sequencer: IDLE -> WAIT_PLL -> RAMP -> RX, with PLL-lock timeout and abort paths.
// Outputs registered from next-state (1 edge); no backpressure. TE_RADIO_SEQ_SYNC_EN adds 2-flop input syncs.
// Source-domain inputs are masked by isolateIn, so an isolated source can never advance or reset the sequence.
module te_radio_seq #(
    parameter int RAMP_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic       ck,
    input  logic       arst,
    input  logic       isolateIn,
    input  logic       pllSettled,
    input  logic       tArstFs,
    input  logic       radioReq,
    input  logic       radioStop,
    output logic       radioEnable,
    output logic       radioRxEn,
    output logic       radioAck,
    output logic       pllTimeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PLL = 3'd1,
        RAMP     = 3'd2,
        RX       = 3'd3,
        TIMEOUT  = 3'd4
    } state_t;

    logic pll_raw;
    logic trst_raw;

`ifdef TE_RADIO_SEQ_SYNC_EN
    logic [1:0] pll_sync_q, pll_sync_d;
    logic [1:0] trst_sync_q, trst_sync_d;

    always_comb begin
        pll_sync_d  = {pll_sync_q[0], pllSettled};
        trst_sync_d = {trst_sync_q[0], tArstFs};
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            pll_sync_q  <= 2'b00;
            trst_sync_q <= 2'b00;
        end else begin
            pll_sync_q  <= pll_sync_d;
            trst_sync_q <= trst_sync_d;
        end
    end

    assign pll_raw  = pll_sync_q[1];
    assign trst_raw = trst_sync_q[1];
`else
    assign pll_raw  = pllSettled;
    assign trst_raw = tArstFs;
`endif

    logic pll_s;
    logic t_rst;
    assign pll_s = pll_raw & ~isolateIn;
    assign t_rst = trst_raw & ~isolateIn;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       radio_enable_q, radio_enable_d;
    logic       radio_rx_en_q, radio_rx_en_d;
    logic       radio_ack_q, radio_ack_d;
    logic       pll_timeout_q, pll_timeout_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (t_rst) begin
            state_d = IDLE;
        end else if (radioStop && state_q != IDLE) begin
            state_d = IDLE;
        end else if (isolateIn && (state_q == RAMP || state_q == RX)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (radioReq && !isolateIn) state_d = WAIT_PLL;
                end
                WAIT_PLL: begin
                    // Lock seen on the final waiting cycle still wins over the timeout.
                    if (pll_s)                                      state_d = RAMP;
                    else if (cnt_q == 8'(TIMEOUT_CYCLES - 1))       state_d = TIMEOUT;
                    else                                            cnt_d   = cnt_q + 8'd1;
                end
                RAMP: begin
                    if (cnt_q == 8'(RAMP_CYCLES - 1)) state_d = RX;
                    else                              cnt_d   = cnt_q + 8'd1;
                end
                RX: begin
                    state_d = RX;
                end
                TIMEOUT: begin
                    if (!radioReq) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (state_d != state_q) cnt_d = 8'd0;

        radio_enable_d = (state_d == WAIT_PLL) || (state_d == RAMP) || (state_d == RX);
        radio_rx_en_d  = (state_d == RX);
        radio_ack_d    = (state_d == RX);
        pll_timeout_d  = (state_d == TIMEOUT) && (state_q != TIMEOUT);
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            radio_enable_q <= 1'b0;
            radio_rx_en_q  <= 1'b0;
            radio_ack_q    <= 1'b0;
            pll_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            radio_enable_q <= radio_enable_d;
            radio_rx_en_q  <= radio_rx_en_d;
            radio_ack_q    <= radio_ack_d;
            pll_timeout_q  <= pll_timeout_d;
        end
    end

    assign radioEnable = radio_enable_q;
    assign radioRxEn   = radio_rx_en_q;
    assign radioAck    = radio_ack_q;
    assign pllTimeout  = pll_timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_te_radio_seq.sv
// Bench for te_radio_seq (default build): directed stimulus pushes expected output-change events
// {edge count, outputs}; a negedge monitor pops one event per observed change and compares.
module tb_te_radio_seq;

    logic       ck = 1'b0;
    logic       arst;
    logic       isolateIn, pllSettled, tArstFs, radioReq, radioStop;
    logic       radioEnable, radioRxEn, radioAck, pllTimeout;
    logic [2:0] state;

    te_radio_seq #(.RAMP_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
        .ck(ck), .arst(arst), .isolateIn(isolateIn), .pllSettled(pllSettled),
        .tArstFs(tArstFs), .radioReq(radioReq), .radioStop(radioStop),
        .radioEnable(radioEnable), .radioRxEn(radioRxEn), .radioAck(radioAck),
        .pllTimeout(pllTimeout), .state(state)
    );

    always #5 ck = ~ck;

    // {state, radioEnable, radioRxEn, radioAck, pllTimeout}
    localparam logic [6:0] V_IDLE = 7'b000_0000;
    localparam logic [6:0] V_WAIT = 7'b001_1000;
    localparam logic [6:0] V_RAMP = 7'b010_1000;
    localparam logic [6:0] V_RX   = 7'b011_1110;
    localparam logic [6:0] V_TMO1 = 7'b100_0001;
    localparam logic [6:0] V_TMO0 = 7'b100_0000;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;

    ev_t        sb[$];
    ev_t        ev;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       mon_en = 1'b0;
    logic [6:0] prev = 7'b0;
    logic [6:0] obs;

    assign obs = {state, radioEnable, radioRxEn, radioAck, pllTimeout};

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        if (mon_en && obs !== prev) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, obs);
            end else begin
                ev = sb.pop_front();
                if (ev.c != cyc || ev.v !== obs) begin
                    failures++;
                    $display("FAIL event got cyc=%0d val=%b, expected cyc=%0d val=%b",
                             cyc, obs, ev.c, ev.v);
                end
            end
            prev = obs;
        end
    end

    task automatic expect_at(input int dt, input logic [6:0] v);
        ev_t e;
        e.c = cyc + dt;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst = 1'b1; isolateIn = 1'b0; pllSettled = 1'b0; tArstFs = 1'b0;
        radioReq = 1'b0; radioStop = 1'b0;
        tick(3);
        chk("reset_state", obs, V_IDLE);
        arst = 1'b0;
        prev = V_IDLE;
        mon_en = 1'b1;
        tick(2);

        // Nominal: lock 10 edges after request, RX 16 edges after lock, then stop.
        radioReq = 1'b1;            expect_at(1, V_WAIT);
        tick(10);
        pllSettled = 1'b1;          expect_at(1, V_RAMP); expect_at(17, V_RX);
        tick(20);
        radioStop = 1'b1; radioReq = 1'b0; expect_at(1, V_IDLE);
        tick(1);
        radioStop = 1'b0; pllSettled = 1'b0;
        tick(3);

        // Timeout: WAIT_PLL lasts exactly 200 edges, one-cycle pulse, exit on request drop.
        radioReq = 1'b1;            expect_at(1, V_WAIT); expect_at(201, V_TMO1); expect_at(202, V_TMO0);
        tick(205);
        radioReq = 1'b0;            expect_at(1, V_IDLE);
        tick(3);

        // Isolation in RX aborts; release with request held restarts the sequence.
        radioReq = 1'b1; pllSettled = 1'b1;
        expect_at(1, V_WAIT); expect_at(2, V_RAMP); expect_at(18, V_RX);
        tick(20);
        isolateIn = 1'b1;           expect_at(1, V_IDLE);
        tick(2);
        isolateIn = 1'b0;           expect_at(1, V_WAIT); expect_at(2, V_RAMP); expect_at(18, V_RX);
        tick(20);
        // Soft reset with request held: IDLE for one edge, then straight back to WAIT_PLL.
        tArstFs = 1'b1;             expect_at(1, V_IDLE);
        tick(1);
        tArstFs = 1'b0;             expect_at(1, V_WAIT); expect_at(2, V_RAMP);
        tick(2);
        radioReq = 1'b0; radioStop = 1'b1; expect_at(1, V_IDLE);
        tick(1);
        radioStop = 1'b0; pllSettled = 1'b0;
        tick(3);

        // Isolated lock and soft reset are both ignored in WAIT_PLL; timer keeps running.
        radioReq = 1'b1;            expect_at(1, V_WAIT);
        tick(1);
        isolateIn = 1'b1; pllSettled = 1'b1; tArstFs = 1'b1;
        expect_at(200, V_TMO1); expect_at(201, V_TMO0);
        tick(205);
        radioReq = 1'b0; isolateIn = 1'b0; pllSettled = 1'b0; tArstFs = 1'b0;
        expect_at(1, V_IDLE);
        tick(3);

        // Soft reset in RAMP with cnt=5.
        radioReq = 1'b1; pllSettled = 1'b1;
        expect_at(1, V_WAIT); expect_at(2, V_RAMP);
        tick(7);
        tArstFs = 1'b1; radioReq = 1'b0; expect_at(1, V_IDLE);
        tick(1);
        tArstFs = 1'b0; pllSettled = 1'b0;
        tick(3);

        // Lock arrives on the cnt=199 edge: RAMP, no timeout pulse.
        radioReq = 1'b1;            expect_at(1, V_WAIT);
        tick(200);
        pllSettled = 1'b1;          expect_at(1, V_RAMP); expect_at(17, V_RX);
        tick(20);

        // Async reset in RX drops outputs before the next edge; no restart until request re-sampled.
        @(posedge ck);
        #2 arst = 1'b1;
        #1 chk("arst_async", obs, V_IDLE);
        expect_at(0, V_IDLE);
        radioReq = 1'b0; pllSettled = 1'b0;
        tick(2);
        arst = 1'b0;
        tick(3);
        radioReq = 1'b1;            expect_at(1, V_WAIT);
        tick(3);
        radioStop = 1'b1;           expect_at(1, V_IDLE);
        tick(1);
        radioStop = 1'b0; radioReq = 1'b0;
        tick(5);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
